// File: rtl/mips_defs.sv
// Shared MIPS encodings and sizing constants for the multiply/divide unit.
package mips_defs;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned MD_CNT_W = 6;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_sign_adj.sv
// Sign adjustment for the multiply/divide unit: either negates each half independently
// (operand magnitudes, quotient/remainder) or negates the full double-width value (product).
module muldiv_sign_adj #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] val_hi_i,
    input  logic [W-1:0] val_lo_i,
    input  logic         neg_hi_i,
    input  logic         neg_lo_i,
    input  logic         neg_full_i,
    output logic [W-1:0] res_hi_o,
    output logic [W-1:0] res_lo_o
);

    localparam int unsigned DW = 2 * W;

    logic [DW-1:0] full_neg;

    always_comb begin
        full_neg = ~{val_hi_i, val_lo_i} + DW'(1);
        if (neg_full_i) begin
            res_hi_o = full_neg[DW-1:W];
            res_lo_o = full_neg[W-1:0];
        end else begin
            res_hi_o = neg_hi_i ? (~val_hi_i + W'(1)) : val_hi_i;
            res_lo_o = neg_lo_i ? (~val_lo_i + W'(1)) : val_lo_i;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one bit per cycle on operand magnitudes,
// shift-add multiply and restoring divide sharing one double-width accumulator.
module muldiv_unit
    import mips_defs::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned CNT_W = MD_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    output logic             busy,
    output logic             hi_lo_wen,
    output logic [WIDTH-1:0] hi_wdata,
    output logic [WIDTH-1:0] lo_wdata
);

    localparam int unsigned DW = 2 * WIDTH;

    md_state_e        state_q;
    md_op_e           op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DW-1:0]    acc_q;
    logic [DW-1:0]    acc_d;
    logic [WIDTH-1:0] b_q;
    logic             neg_a_q;
    logic             neg_b_q;
    logic             dz_q;
    logic             busy_q;
    logic             wen_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    md_op_e           op_c;
    logic             neg_a_c;
    logic             neg_b_c;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             is_div;
    logic             sign_diff;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;

    assign op_c    = md_op_e'(op);
    assign neg_a_c = md_is_signed(op_c) & src1[WIDTH-1];
    assign neg_b_c = md_is_signed(op_c) & src2[WIDTH-1];

    // Operand magnitudes; 0x80000000 maps to 2^31 as an unsigned value.
    muldiv_sign_adj #(.W(WIDTH)) u_pre (
        .val_hi_i   (src1),
        .val_lo_i   (src2),
        .neg_hi_i   (neg_a_c),
        .neg_lo_i   (neg_b_c),
        .neg_full_i (1'b0),
        .res_hi_o   (abs_a),
        .res_lo_o   (abs_b)
    );

    assign is_div    = md_is_div(op_q);
    assign sign_diff = neg_a_q ^ neg_b_q;

    // One iteration: multiply holds {partial, multiplier}, divide holds {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_shift = acc_q[DW-1:WIDTH-1];
        div_ge    = div_shift >= {1'b0, b_q};
        div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, b_q}) : div_shift[WIDTH-1:0];
        if (is_div) begin
            acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Final signs: product negated as a whole, quotient/remainder separately.
    muldiv_sign_adj #(.W(WIDTH)) u_post (
        .val_hi_i   (acc_d[DW-1:WIDTH]),
        .val_lo_i   (acc_d[WIDTH-1:0]),
        .neg_hi_i   (is_div & neg_a_q),
        .neg_lo_i   (is_div & sign_diff),
        .neg_full_i (~is_div & sign_diff),
        .res_hi_o   (res_hi),
        .res_lo_o   (res_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            op_q    <= MD_MULT;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            wen_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (flush) begin
            state_q <= MD_IDLE;
            busy_q  <= 1'b0;
            wen_q   <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    wen_q <= 1'b0;
                    if (start) begin
                        op_q    <= op_c;
                        neg_a_q <= neg_a_c;
                        neg_b_q <= neg_b_c;
                        dz_q    <= (src2 == '0);
                        acc_q   <= md_is_div(op_c) ? {WIDTH'(0), abs_a} : {WIDTH'(0), abs_b};
                        b_q     <= md_is_div(op_c) ? abs_b : abs_a;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= MD_CALC;
                    end
                end
                MD_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        hi_q    <= res_hi;
                        lo_q    <= (is_div && dz_q) ? '1 : res_lo;
                        wen_q   <= 1'b1;
                        state_q <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    wen_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= MD_IDLE;
                end
                default: begin
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign hi_lo_wen = wen_q & ~flush;
    assign hi_wdata  = hi_q;
    assign lo_wdata  = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model plus per-cycle timing/data checks.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        hi_lo_wen;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .busy      (busy),
        .hi_lo_wen (hi_lo_wen),
        .hi_wdata  (hi_wdata),
        .lo_wdata  (lo_wdata)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          chk_en  = 1'b0;
    int          launch_cyc = -1000;
    int          abort_cyc  = 1 << 30;
    int          rst_cyc    = -1000;
    logic [63:0] exp_res = '0;
    logic [63:0] lit_res = '0;
    logic [31:0] hold_hi = '0;
    logic [31:0] hold_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Reference results straight from the MIPS arithmetic definitions, as {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        u  = '0;
        case (o)
            2'b00: u = 64'(sa * sb);
            2'b01: u = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) begin
                    u = {a, 32'hFFFFFFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    u = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) u = {a, 32'hFFFFFFFF};
                else            u = {a % b, a / b};
            end
        endcase
        return u;
    endfunction

    // Timing: busy in cycles launch+1..launch+33, write strobe only in launch+33, cut short by abort.
    always @(negedge clk) begin : mon
        bit eb;
        bit ew;
        if (chk_en) begin
            if (cyc == rst_cyc + 1) begin
                hold_hi = '0;
                hold_lo = '0;
            end
            eb = (cyc >= launch_cyc + 1) && (cyc <= launch_cyc + 33) && (cyc <= abort_cyc);
            ew = (cyc == launch_cyc + 33) && (cyc < abort_cyc);
            check32("busy", 32'(busy), 32'(eb));
            check32("hi_lo_wen", 32'(hi_lo_wen), 32'(ew));
            if (ew) begin
                check32("hi_model", hi_wdata, exp_res[63:32]);
                check32("lo_model", lo_wdata, exp_res[31:0]);
                check32("hi_literal", hi_wdata, lit_res[63:32]);
                check32("lo_literal", lo_wdata, lit_res[31:0]);
                hold_hi = exp_res[63:32];
                hold_lo = exp_res[31:0];
            end else begin
                check32("hi_hold", hi_wdata, hold_hi);
                check32("lo_hold", lo_wdata, hold_lo);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] lit);
        op         = o;
        src1       = a;
        src2       = b;
        start      = 1'b1;
        launch_cyc = cyc;
        abort_cyc  = 1 << 30;
        exp_res    = model(o, a, b);
        lit_res    = lit;
        check32("model_pin_hi", exp_res[63:32], lit[63:32]);
        check32("model_pin_lo", exp_res[31:0], lit[31:0]);
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        src1  = $urandom;
        src2  = $urandom;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        src1  = '0;
        src2  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        idle(2);

        go(2'b00, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1); idle(33);
        go(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001); idle(33);
        go(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001); idle(33);
        go(2'b10, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD); idle(33);
        go(2'b11, 32'd7,        32'd2,        64'h00000001_00000003); idle(33);
        go(2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000); idle(33);
        go(2'b11, 32'h00001234, 32'd0,        64'h00001234_FFFFFFFF); idle(33);
        go(2'b01, 32'd0,        32'h00012345, 64'h00000000_00000000); idle(33);
        go(2'b11, 32'd0,        32'd7,        64'h00000000_00000000); idle(33);
        go(2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000); idle(33);
        go(2'b10, 32'hFFFFFFF9, 32'd0,        64'hFFFFFFF9_FFFFFFFF); idle(33);
        go(2'b10, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD); idle(33);

        // Flush in cycle 10 of a divide, then relaunch in cycle 11.
        go(2'b10, 32'd100, 32'd7, 64'h00000002_0000000E);
        idle(9);
        flush     = 1'b1;
        abort_cyc = cyc;
        idle(1);
        flush = 1'b0;
        go(2'b01, 32'd3, 32'd4, 64'h00000000_0000000C); idle(33);

        // A start while busy must be ignored.
        go(2'b00, 32'd6, 32'd7, 64'h00000000_0000002A);
        idle(4);
        op    = 2'b01;
        src1  = 32'd9;
        src2  = 32'd9;
        start = 1'b1;
        idle(1);
        start = 1'b0;
        idle(28);

        // Reset in cycle 20 of an operation: no write, outputs cleared.
        go(2'b11, 32'd1000, 32'd3, 64'h00000001_0000014D);
        idle(19);
        rst       = 1'b1;
        rst_cyc   = cyc;
        abort_cyc = cyc;
        idle(1);
        rst = 1'b0;
        idle(3);

        // Flush and start together in IDLE: nothing launches.
        op    = 2'b01;
        src1  = 32'd5;
        src2  = 32'd5;
        start = 1'b1;
        flush = 1'b1;
        idle(1);
        start = 1'b0;
        flush = 1'b0;
        idle(3);

        go(2'b01, 32'h00010000, 32'h00010000, 64'h00000001_00000000); idle(33);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative 32-bit multiply/divide unit for the MIPS datapath. It executes MULT, MULTU, DIV and DIVU at one bit per cycle, using a shift-add multiplier and a restoring divider. It sits directly upstream of the register file's HI/LO write port and drives its hi_lo_wen, hi_wdata and lo_wdata inputs. The decode stage launches an operation with a start pulse and stalls while busy is high.

Parameters:
WIDTH, 32, operand width. Only 32 is supported and verified.
CNT_W, 6, iteration counter width. Must hold the value WIDTH.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  launch request; sampled only in IDLE
op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
src1  input  WIDTH  multiplicand or dividend; sampled with start
src2  input  WIDTH  multiplier or divisor; sampled with start
flush  input  1  abort the in-flight operation (exception or branch flush)
busy  output  1  operation in progress; the stage above must stall
hi_lo_wen  output  1  one-cycle write strobe to the register file's HI/LO port
hi_wdata  output  WIDTH  HI result
lo_wdata  output  WIDTH  LO result

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset values: state IDLE; busy=0, hi_lo_wen=0, hi_wdata=0, lo_wdata=0; counter=0; internal accumulators cleared.
- State machine IDLE -> CALC -> DONE -> IDLE.
  - IDLE: if start=1 and flush=0, latch op, operand magnitudes and the result-sign flags; clear counter; go to CALC.
  - CALC: one iteration per cycle. After WIDTH (32) iterations, go to DONE.
  - DONE: hi_lo_wen=1 with final results; go to IDLE on the next edge.
- Latency: start sampled high in cycle 0 → busy=1 in cycles 1..33, hi_lo_wen=1 in cycle 33 only, IDLE again in cycle 34.
- A new start may be sampled in cycle 34 at the earliest.
- busy is 1 in CALC and DONE.
- start while busy is ignored; no queueing.
- hi_wdata/lo_wdata hold their last values outside DONE. They are qualified only by hi_lo_wen.
- Multiply (shift-add on unsigned magnitudes, 64-bit product):
  - hi = product[63:32], lo = product[31:0].
  - Signed: magnitudes |src1|, |src2| in 32-bit unsigned; 0x80000000 maps to 2^31 without overflow.
  - Signed: product is negated at the end (two's complement over 64 bits) when sign(src1) != sign(src2) and the product is nonzero.
- Divide (restoring, unsigned magnitudes):
  - lo = quotient, hi = remainder.
  - Signed: quotient negated when the operand signs differ.
  - Signed: remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0. No trap.
- Divide by zero (DIV or DIVU): lo=0xFFFFFFFF, hi=src1 unmodified. Still 33-cycle latency; hi_lo_wen still pulses.
- flush=1 in any state: next state IDLE, no hi_lo_wen pulse, busy=0 next cycle; outputs hi/lo data unchanged.
  - flush in DONE: hi_lo_wen is masked combinationally in that same cycle.
  - flush and start together in IDLE: flush wins; nothing launches.
- rst mid-operation: returns to reset values on the next edge; no write is issued.
- MULTU 0 × anything and DIVU 0 / nonzero complete normally with zero results.

Decomposition:
- Shared package (mips_defs):
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU
  - state encodings MD_IDLE, MD_CALC, MD_DONE
  - WIDTH default constant
- One sub-module: muldiv_sign_adj, purely combinational.
  - Pre-phase: operand absolute values and sign flags.
  - Post-phase: conditional 64-bit negation of the product, and separate quotient and remainder negation.
  - Instantiated once for pre and once for post.
- The iteration datapath and FSM stay in muldiv_unit.

Test Plan:
- MULT src1=0xFFFFFFFD (-3), src2=5 → cycle 33: hi_lo_wen=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy=1 cycles 1..33 exactly.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. MULT same operands → hi=0, lo=1.
- DIV 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 0x1234 / 0 → lo=0xFFFFFFFF, hi=0x00001234 at cycle 33.
- Start DIV, assert flush in cycle 10 → busy=0 from cycle 11, no hi_lo_wen. Second start in cycle 11 with MULTU 3×4 → hi=0, lo=12 at cycle 44.
- Start while busy (new operands in cycle 5) ignored, first result unchanged. rst in cycle 20 → all outputs 0 next cycle, no write. flush+start together in IDLE → busy stays 0.
